ysyx_22040759_mem_arbiter: RTL and testbench

YSYX_22040759_MEM_ARBITER -- requirements
Module: ysyx_22040759_mem_arbiter

---
 rtl/ysyx_22040759_mem_arbiter.sv | 226 ++++++++++++++++++++++
 tb/tb_ysyx_22040759_mem_arbiter.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040759_mem_arbiter.sv
// Two-requester (fetch / load-store) arbiter onto a single memory port.
// Round-robin grant, one outstanding transaction, per-transaction timeout.
//
// Handshake: a requester holds *_req until its combinational *_gnt pulse (IDLE only);
// mem_req is held with stable mem_* until mem_ready is sampled high; mem_rvalid is
// accepted only in WAIT; *_rvalid is a single-cycle pulse with no back-pressure.
module ysyx_22040759_mem_arbiter #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [63:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_inst,
  output logic        if_err,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [63:0] ls_addr,
  input  logic [63:0] ls_wdata,
  input  logic [7:0]  ls_wmask,
  output logic        ls_gnt,
  output logic        ls_rvalid,
  output logic [63:0] ls_rdata,
  output logic        ls_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYC - 1);
  localparam logic [31:0] NOP_INST     = 32'h0000_0013;

  state_t      r_state;
  logic        r_prio_if;
  logic        r_owner_ls;
  logic        r_we;
  logic        r_addr_hi;
  logic [15:0] r_cnt;

  logic        r_mem_req;
  logic        r_mem_we;
  logic [63:0] r_mem_addr;
  logic [63:0] r_mem_wdata;
  logic [7:0]  r_mem_wmask;

  logic        r_if_rvalid;
  logic [31:0] r_if_inst;
  logic        r_if_err;
  logic        r_ls_rvalid;
  logic [63:0] r_ls_rdata;
  logic        r_ls_err;

  logic        w_idle;
  logic        w_ls_gnt;
  logic        w_if_gnt;
  logic        w_if_null;
  logic        w_if_mis;
  logic        w_cnt_hit;
  logic [31:0] w_fetch_word;
  logic        w_unused;

  // Grants are gated by rst_n so every output reads 0 while reset is held.
  assign w_idle       = (r_state == S_IDLE) && rst_n;
  assign w_ls_gnt     = w_idle && ls_req && (!if_req || !r_prio_if);
  assign w_if_gnt     = w_idle && if_req && !w_ls_gnt;
  assign w_if_null    = (if_addr == 64'd0);
  assign w_if_mis     = (if_addr[1:0] != 2'b00);
  assign w_cnt_hit    = (r_cnt == TIMEOUT_LAST);
  assign w_fetch_word = r_addr_hi ? mem_rdata[63:32] : mem_rdata[31:0];
  assign w_unused     = ^ls_addr[2:0];

  assign if_gnt    = w_if_gnt;
  assign ls_gnt    = w_ls_gnt;
  assign if_rvalid = r_if_rvalid;
  assign if_inst   = r_if_inst;
  assign if_err    = r_if_err;
  assign ls_rvalid = r_ls_rvalid;
  assign ls_rdata  = r_ls_rdata;
  assign ls_err    = r_ls_err;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_wmask = r_mem_wmask;
  assign dbg_state = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_prio_if   <= 1'b0;
      r_owner_ls  <= 1'b0;
      r_we        <= 1'b0;
      r_addr_hi   <= 1'b0;
      r_cnt       <= 16'd0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 64'd0;
      r_mem_wdata <= 64'd0;
      r_mem_wmask <= 8'd0;
      r_if_rvalid <= 1'b0;
      r_if_inst   <= 32'd0;
      r_if_err    <= 1'b0;
      r_ls_rvalid <= 1'b0;
      r_ls_rdata  <= 64'd0;
      r_ls_err    <= 1'b0;
    end else begin
      // Response outputs live for exactly the RESP cycle; set only on entry.
      r_if_rvalid <= 1'b0;
      r_if_inst   <= 32'd0;
      r_if_err    <= 1'b0;
      r_ls_rvalid <= 1'b0;
      r_ls_rdata  <= 64'd0;
      r_ls_err    <= 1'b0;

      case (r_state)
        S_IDLE: begin
          r_cnt <= 16'd0;
          if (w_ls_gnt) begin
            r_owner_ls  <= 1'b1;
            r_prio_if   <= 1'b1;
            r_we        <= ls_we;
            r_addr_hi   <= 1'b0;
            r_mem_req   <= 1'b1;
            r_mem_we    <= ls_we;
            r_mem_addr  <= {ls_addr[63:3], 3'b000};
            r_mem_wdata <= ls_wdata;
            r_mem_wmask <= ls_wmask;
            r_state     <= S_REQ;
          end else if (w_if_gnt) begin
            r_owner_ls <= 1'b0;
            r_prio_if  <= 1'b0;
            r_we       <= 1'b0;
            r_addr_hi  <= if_addr[2];
            if (w_if_null) begin
              r_if_rvalid <= 1'b1;
              r_if_inst   <= NOP_INST;
              r_state     <= S_RESP;
            end else if (w_if_mis) begin
              r_if_rvalid <= 1'b1;
              r_if_err    <= 1'b1;
              r_state     <= S_RESP;
            end else begin
              r_mem_req   <= 1'b1;
              r_mem_we    <= 1'b0;
              r_mem_addr  <= {if_addr[63:3], 3'b000};
              r_mem_wdata <= 64'd0;
              r_mem_wmask <= 8'd0;
              r_state     <= S_REQ;
            end
          end
        end

        S_REQ: begin
          if (mem_ready || w_cnt_hit) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 64'd0;
            r_mem_wdata <= 64'd0;
            r_mem_wmask <= 8'd0;
            r_cnt       <= 16'd0;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
          // A ready arriving on the last allowed cycle still wins over the abort.
          if (mem_ready) begin
            r_state <= S_WAIT;
          end else if (w_cnt_hit) begin
            r_if_rvalid <= !r_owner_ls;
            r_if_err    <= !r_owner_ls;
            r_ls_rvalid <= r_owner_ls;
            r_ls_err    <= r_owner_ls;
            r_state     <= S_RESP;
          end
        end

        S_WAIT: begin
          if (mem_rvalid) begin
            r_cnt <= 16'd0;
            if (r_owner_ls) begin
              r_ls_rvalid <= 1'b1;
              r_ls_rdata  <= r_we ? 64'd0 : mem_rdata;
            end else begin
              r_if_rvalid <= 1'b1;
              r_if_inst   <= w_fetch_word;
            end
            r_state <= S_RESP;
          end else if (w_cnt_hit) begin
            r_cnt       <= 16'd0;
            r_if_rvalid <= !r_owner_ls;
            r_if_err    <= !r_owner_ls;
            r_ls_rvalid <= r_owner_ls;
            r_ls_err    <= r_owner_ls;
            r_state     <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end

        S_RESP: begin
          r_cnt   <= 16'd0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22040759_mem_arbiter.sv
// Directed bench for the fetch/load-store memory arbiter: drivers push expected
// grants, memory requests and responses into queues; a negedge monitor pops and checks.
module tb_ysyx_22040759_mem_arbiter;

  localparam int TO = 4;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [63:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_inst;
  logic        if_err;
  logic        ls_req;
  logic        ls_we;
  logic [63:0] ls_addr;
  logic [63:0] ls_wdata;
  logic [7:0]  ls_wmask;
  logic        ls_gnt;
  logic        ls_rvalid;
  logic [63:0] ls_rdata;
  logic        ls_err;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  logic [1:0]  dbg_state;

  ysyx_22040759_mem_arbiter #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_inst(if_inst), .if_err(if_err),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_wmask(ls_wmask), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .ls_err(ls_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  int last_gnt_cyc = 0;

  // {latency[7:0], is_ls, err, data[63:0]}
  logic [73:0]  exp_q[$];
  // {we, wmask[7:0], addr[63:0], wdata[63:0]}
  logic [136:0] mem_q[$];
  logic         gnt_q[$];
  logic [63:0]  rr_rd[4];

  logic [73:0]  m_exp, m_got;
  logic [136:0] m_mexp;
  logic         m_g;

  task automatic chk(input string name, input logic [136:0] got, input logic [136:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic exp_push(input int lat, input logic ls, input logic err, input logic [63:0] d);
    exp_q.push_back({8'(lat), ls, err, d});
  endtask

  task automatic mem_push(input logic we, input logic [7:0] wm, input logic [63:0] a,
                          input logic [63:0] wd);
    mem_q.push_back({we, wm, a, wd});
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("exclusive", {135'd0, if_gnt & ls_gnt, if_rvalid & ls_rvalid}, 137'd0);
      chk("quiet_outs", {39'd0, (if_rvalid ? 33'd0 : {if_err, if_inst}),
                         (ls_rvalid ? 65'd0 : {ls_err, ls_rdata})}, 137'd0);
      if (if_gnt || ls_gnt) begin
        last_gnt_cyc = cyc;
        if (gnt_q.size() == 0) begin
          chk("unexpected_gnt", {135'd0, if_gnt, ls_gnt}, 137'd0);
        end else begin
          m_g = gnt_q.pop_front();
          chk("gnt_side", {136'd0, ls_gnt}, {136'd0, m_g});
        end
      end
      if (mem_req && mem_ready) begin
        if (mem_q.size() == 0) begin
          chk("unexpected_mem", {136'd0, mem_req}, 137'd0);
        end else begin
          m_mexp = mem_q.pop_front();
          chk("mem_txn", {mem_we, mem_wmask, mem_addr, mem_wdata}, m_mexp);
        end
      end
      if (if_rvalid || ls_rvalid) begin
        m_got = {8'(cyc - last_gnt_cyc), ls_rvalid, (ls_rvalid ? ls_err : if_err),
                 (ls_rvalid ? ls_rdata : {32'd0, if_inst})};
        if (exp_q.size() == 0) begin
          chk("unexpected_rvalid", {63'd0, m_got}, 137'd0);
        end else begin
          m_exp = exp_q.pop_front();
          chk("resp", {63'd0, m_got}, {63'd0, m_exp});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_any_gnt(output int gc);
    bit ok;
    ok = 1'b0;
    gc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (if_gnt || ls_gnt) begin
        ok = 1'b1;
        gc = cyc;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL gnt_wait: got no grant within 40 cycles, expected a grant");
    end
    @(posedge clk);
    #2;
  endtask

  // Wait for the grant, then drop the request and scramble inputs to prove capture.
  task automatic grant();
    int gc;
    wait_any_gnt(gc);
    if_req   = 1'b0;
    ls_req   = 1'b0;
    if_addr  = 64'hFFFF_FFFF_FFFF_FFF0;
    ls_we    = ~ls_we;
    ls_addr  = 64'h1234_5678_9ABC_DEF8;
    ls_wdata = 64'h5A5A_5A5A_5A5A_5A5A;
    ls_wmask = 8'hFF;
  endtask

  task automatic issue_if(input logic [63:0] a);
    if_addr = a;
    if_req  = 1'b1;
  endtask

  task automatic issue_ls(input logic we, input logic [63:0] a, input logic [63:0] wd,
                          input logic [7:0] wm);
    ls_we    = we;
    ls_addr  = a;
    ls_wdata = wd;
    ls_wmask = wm;
    ls_req   = 1'b1;
  endtask

  // Called the cycle after grant (DUT in REQ); mem_rvalid is driven high while
  // waiting for ready to show it is ignored outside WAIT.
  task automatic serve(input int rdy_dly, input int rv_dly, input logic [63:0] rd);
    for (int i = 0; i < rdy_dly; i++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 64'hBADB_ADBA_DBAD_BADB;
      step();
    end
    mem_rvalid = 1'b0;
    mem_ready  = 1'b1;
    step();
    mem_ready = 1'b0;
    for (int i = 0; i < rv_dly; i++) step();
    mem_rvalid = 1'b1;
    mem_rdata  = rd;
    step();
    mem_rvalid = 1'b0;
    mem_rdata  = 64'd0;
    step();
  endtask

  task automatic rr_run(input int n);
    int gc, prev;
    logic [31:0] gap;
    prev = 0;
    for (int k = 0; k < n; k++) begin
      wait_any_gnt(gc);
      if (k > 0) begin
        gap = 32'(gc - prev);
        chk("rr_gap", {105'd0, gap}, 137'd4);
      end
      prev = gc;
      if (k == n - 1) begin
        if_req = 1'b0;
        ls_req = 1'b0;
      end
      serve(0, 0, rr_rd[k]);
    end
  endtask

  task automatic chk_no_mem(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("no_mem_req", {136'd0, mem_req}, 137'd0);
    end
    @(posedge clk);
    #2;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt;
    rst_n = 1'b0; if_req = 1'b0; if_addr = 64'd0;
    ls_req = 1'b0; ls_we = 1'b0; ls_addr = 64'd0; ls_wdata = 64'd0; ls_wmask = 8'd0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 64'd0;

    // Both requesters held from reset: grants must alternate LS, IF, LS, IF.
    if_addr = 64'h0000_0000_8000_0010;
    ls_addr = 64'h0000_0000_8000_2000;
    if_req = 1'b1;
    ls_req = 1'b1;
    repeat (3) step();
    chk("rst_resp", {35'd0, if_gnt, if_rvalid, if_inst, if_err, ls_gnt, ls_rvalid, ls_rdata,
                     ls_err}, 137'd0);
    chk("rst_mem", {54'd0, mem_req, mem_we, mem_wmask, dbg_state, mem_addr}, 137'd0);
    chk("rst_wdata", {73'd0, mem_wdata}, 137'd0);

    rr_rd[0] = 64'h0123_4567_89AB_CDEF;
    rr_rd[1] = 64'hFEDC_BA98_7654_3210;
    rr_rd[2] = 64'h0F0F_0F0F_F0F0_F0F0;
    rr_rd[3] = 64'hA5A5_5A5A_1234_5678;
    gnt_q.push_back(1'b1); gnt_q.push_back(1'b0);
    gnt_q.push_back(1'b1); gnt_q.push_back(1'b0);
    mem_push(1'b0, 8'h00, 64'h8000_2000, 64'd0);
    mem_push(1'b0, 8'h00, 64'h8000_0010, 64'd0);
    mem_push(1'b0, 8'h00, 64'h8000_2000, 64'd0);
    mem_push(1'b0, 8'h00, 64'h8000_0010, 64'd0);
    exp_push(3, 1'b1, 1'b0, 64'h0123_4567_89AB_CDEF);
    exp_push(3, 1'b0, 1'b0, 64'h7654_3210);
    exp_push(3, 1'b1, 1'b0, 64'h0F0F_0F0F_F0F0_F0F0);
    exp_push(3, 1'b0, 1'b0, 64'h1234_5678);
    rst_n = 1'b1;
    rr_run(4);

    // Fetch from the upper word, minimum latency.
    gnt_q.push_back(1'b0);
    mem_push(1'b0, 8'h00, 64'h8000_0000, 64'd0);
    exp_push(3, 1'b0, 1'b0, 64'h1111_2222);
    issue_if(64'h8000_0004);
    grant();
    serve(0, 0, 64'h1111_2222_3333_4444);

    // Byte write: completion carries zero data even if memory returns garbage.
    gnt_q.push_back(1'b1);
    mem_push(1'b1, 8'h01, 64'h8000_1008, 64'h0000_0000_0000_00AA);
    exp_push(3, 1'b1, 1'b0, 64'd0);
    issue_ls(1'b1, 64'h8000_1008, 64'h0000_0000_0000_00AA, 8'h01);
    grant();
    serve(0, 0, 64'hFFFF_0000_FFFF_0000);

    // Unaligned load address is word-aligned on the bus; slow ready and rvalid.
    gnt_q.push_back(1'b1);
    mem_push(1'b0, 8'h00, 64'h8000_3000, 64'd0);
    exp_push(6, 1'b1, 1'b0, 64'h5555_AAAA_1234_ABCD);
    issue_ls(1'b0, 64'h8000_3005, 64'd0, 8'h00);
    grant();
    serve(2, 1, 64'h5555_AAAA_1234_ABCD);

    // Null fetch: NOP next cycle, no bus traffic.
    gnt_q.push_back(1'b0);
    exp_push(1, 1'b0, 1'b0, 64'h0000_0013);
    issue_if(64'd0);
    grant();
    chk_no_mem(3);

    // Misaligned fetch: error next cycle, no bus traffic.
    gnt_q.push_back(1'b0);
    exp_push(1, 1'b0, 1'b1, 64'd0);
    issue_if(64'h8000_0002);
    grant();
    chk_no_mem(3);

    // Fetch from the lower word.
    gnt_q.push_back(1'b0);
    mem_push(1'b0, 8'h00, 64'h8000_0008, 64'd0);
    exp_push(4, 1'b0, 1'b0, 64'hDEAD_BEEF);
    issue_if(64'h8000_0008);
    grant();
    serve(1, 0, 64'hCAFE_BABE_DEAD_BEEF);

    // Timeout while waiting for mem_ready.
    gnt_q.push_back(1'b1);
    exp_push(5, 1'b1, 1'b1, 64'd0);
    issue_ls(1'b0, 64'h8000_4000, 64'd0, 8'h00);
    grant();
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (mem_req) cnt++;
    end
    chk("to_req_cycles", 137'(cnt), 137'(TO));
    @(posedge clk);
    #2;

    // Timeout while waiting for mem_rvalid.
    gnt_q.push_back(1'b0);
    mem_push(1'b0, 8'h00, 64'h8000_0100, 64'd0);
    exp_push(6, 1'b0, 1'b1, 64'd0);
    issue_if(64'h8000_0104);
    grant();
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    repeat (6) step();

    // Reset in WAIT: no response, late rvalid ignored.
    gnt_q.push_back(1'b1);
    mem_push(1'b0, 8'h00, 64'h8000_5000, 64'd0);
    issue_ls(1'b0, 64'h8000_5000, 64'd0, 8'h00);
    grant();
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_resp", {35'd0, if_gnt, if_rvalid, if_inst, if_err, ls_gnt, ls_rvalid, ls_rdata,
                      ls_err}, 137'd0);
    chk("arst_mem", {54'd0, mem_req, mem_we, mem_wmask, dbg_state, mem_addr}, 137'd0);
    chk("arst_wdata", {73'd0, mem_wdata}, 137'd0);
    step();
    rst_n = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 64'hDEAD_DEAD_DEAD_DEAD;
    step();
    mem_rvalid = 1'b0;
    mem_rdata  = 64'd0;
    repeat (2) step();

    // After reset the pointer favours LSU again; both served normally.
    rr_rd[0] = 64'h1357_9BDF_2468_ACE0;
    rr_rd[1] = 64'h89AB_CDEF_0000_1111;
    gnt_q.push_back(1'b1); gnt_q.push_back(1'b0);
    mem_push(1'b0, 8'h00, 64'h8000_6000, 64'd0);
    mem_push(1'b0, 8'h00, 64'h8000_0200, 64'd0);
    exp_push(3, 1'b1, 1'b0, 64'h1357_9BDF_2468_ACE0);
    exp_push(3, 1'b0, 1'b0, 64'h89AB_CDEF);
    if_addr  = 64'h8000_0204;
    ls_we    = 1'b0;
    ls_addr  = 64'h8000_6000;
    ls_wdata = 64'd0;
    ls_wmask = 8'h00;
    if_req   = 1'b1;
    ls_req   = 1'b1;
    rr_run(2);

    repeat (3) step();
    chk("exp_q_left", 137'(exp_q.size()), 137'd0);
    chk("mem_q_left", 137'(mem_q.size()), 137'd0);
    chk("gnt_q_left", 137'(gnt_q.size()), 137'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    bad++;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
